// File: rtl/axil_pkg.sv
// Shared response codes and channel FSM state types for the register-file slave.
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}           r_state_e;
endpackage

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite-style bus bundle (AW, W, B, AR, R) seen from master and slave sides.
interface axil_regfile_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0]   aw_addr;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axil_regfile_mem.sv
// DEPTH x DATA_W register storage: byte-strobed write port, combinational read port
// (returns 0 out of range) and a fixed tap for the display register.
module axil_regfile_mem #(
  parameter int          ADDR_W   = 4,
  parameter int          DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DISP_IDX = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   disp_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en && (32'(wr_addr) == i)) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (wr_strb[b]) mem_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Mux by explicit compare so addresses beyond DEPTH fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(rd_addr) == i) rd_data = mem_q[i];
    end
  end

  assign disp_data = mem_q[DISP_IDX];
endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite-style register-file slave: one outstanding write (AW/W captured independently,
// commit one edge later), one read at a time; out-of-range accesses answer SLVERR.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter int          DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DISP_IDX = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axil_regfile_slave_if.slave   bus,
  output logic [DATA_W-1:0]     disp_out
);
  w_state_e            w_state_q, w_state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
  logic [1:0]          b_resp_q, b_resp_d;

  r_state_e            r_state_q, r_state_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;

  logic                mem_wr_en;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                wr_in_range, rd_in_range;

  assign wr_in_range = 32'(aw_addr_q) < DEPTH;
  assign rd_in_range = 32'(bus.ar_addr) < DEPTH;

  axil_regfile_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DISP_IDX(DISP_IDX)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (mem_wr_en),
    .wr_addr  (aw_addr_q),
    .wr_data  (w_data_q),
    .wr_strb  (w_strb_q),
    .rd_addr  (bus.ar_addr),
    .rd_data  (mem_rd_data),
    .disp_data(disp_out)
  );

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_resp_d  = b_resp_q;
    mem_wr_en = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.aw_valid && !aw_held_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = bus.aw_addr;
        end
        if (bus.w_valid && !w_held_q) begin
          w_held_d = 1'b1;
          w_data_d = bus.w_data;
          w_strb_d = bus.w_strb;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        mem_wr_en = wr_in_range;
        b_resp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bus.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read data is sampled from the pre-commit array, so a same-edge write is not visible.
  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.ar_valid) begin
          r_data_d  = mem_rd_data;
          r_resp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.r_ready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign bus.aw_ready = (w_state_q == W_IDLE) && !aw_held_q;
  assign bus.w_ready  = (w_state_q == W_IDLE) && !w_held_q;
  assign bus.b_valid  = (w_state_q == W_RESP);
  assign bus.b_resp   = b_resp_q;
  assign bus.ar_ready = (r_state_q == R_IDLE);
  assign bus.r_valid  = (r_state_q == R_DATA);
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
endmodule

// File: tb/tb_axil_regfile_slave.sv
// Bench for axil_regfile_slave (ADDR_W=4, DATA_W=16, DEPTH=12): directed cases plus random
// traffic, checked against an array model of the register file.
module tb_axil_regfile_slave;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] disp_out;
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] model [16];

  always #5 clk = ~clk;

  axil_regfile_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_regfile_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DISP_IDX(0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .disp_out(disp_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    return (a < DEPTH) ? model[a] : '0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] a);
    return (a < DEPTH) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [1:0] s);
    if (a < DEPTH) begin
      if (s[0]) model[a][7:0]  = d[7:0];
      if (s[1]) model[a][15:8] = d[15:8];
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [1:0] s, input int aw_dly, input int w_dly,
                          input int b_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (w_done && !aw_done) chk("w_rdy_hold", bus.w_ready, 0);
      if (aw_done && !w_done) chk("aw_rdy_hold", bus.aw_ready, 0);
      if (aw_done != w_done) chk("b_vld_early", bus.b_valid, 0);
      bus.aw_addr  = a;
      bus.aw_valid = !aw_done && (cyc >= aw_dly);
      bus.w_data   = d;
      bus.w_strb   = s;
      bus.w_valid  = !w_done && (cyc >= w_dly);
      if (bus.aw_valid && bus.aw_ready) aw_done = 1'b1;
      if (bus.w_valid && bus.w_ready) w_done = 1'b1;
      cyc++;
    end
    chk("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
    @(negedge clk);
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    chk("b_vld_commit", bus.b_valid, 0);
    chk("aw_rdy_commit", bus.aw_ready, 0);
    model_write(a, d, s);
    @(negedge clk);
    chk("b_vld", bus.b_valid, 1);
    chk("b_resp", bus.b_resp, exp_resp(a));
    chk("disp_out", disp_out, model[0]);
    // A second AW offered during the stall must not be taken.
    bus.aw_addr  = a + 4'd1;
    bus.aw_valid = (b_dly > 0);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("b_vld_stall", bus.b_valid, 1);
      chk("b_resp_stall", bus.b_resp, exp_resp(a));
      chk("aw_rdy_stall", bus.aw_ready, 0);
      chk("w_rdy_stall", bus.w_ready, 0);
    end
    bus.aw_valid = 1'b0;
    bus.b_ready  = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    chk("b_vld_done", bus.b_valid, 0);
    chk("aw_rdy_done", bus.aw_ready, 1);
    chk("w_rdy_done", bus.w_ready, 1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int r_dly);
    logic [DATA_W-1:0] ed;
    @(negedge clk);
    chk("ar_rdy_idle", bus.ar_ready, 1);
    bus.ar_addr  = a;
    bus.ar_valid = 1'b1;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    ed = exp_data(a);
    chk("r_vld", bus.r_valid, 1);
    chk("r_data", bus.r_data, ed);
    chk("r_resp", bus.r_resp, exp_resp(a));
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("r_vld_stall", bus.r_valid, 1);
      chk("r_data_stall", bus.r_data, ed);
      chk("ar_rdy_stall", bus.ar_ready, 0);
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    chk("r_vld_done", bus.r_valid, 0);
    chk("ar_rdy_done", bus.ar_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data  = '0; bus.w_strb   = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_aw_rdy", bus.aw_ready, 1);
    chk("rst_w_rdy", bus.w_ready, 1);
    chk("rst_ar_rdy", bus.ar_ready, 1);
    chk("rst_b_vld", bus.b_valid, 0);
    chk("rst_r_vld", bus.r_valid, 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_resps", {bus.b_resp, bus.r_resp}, 0);
    chk("rst_disp", disp_out, 0);
    rst_n = 1'b1;

    do_write(4'd3, 16'h00A5, 2'b01, 0, 0, 0);
    do_read(4'd3, 0);
    do_write(4'd0, 16'h004C, 2'b01, 3, 0, 0);
    do_write(4'd13, 16'hFFFF, 2'b11, 0, 0, 5);
    do_read(4'd13, 5);
    do_write(4'd2, 16'h1234, 2'b11, 0, 1, 0);
    do_write(4'd2, 16'hABCD, 2'b10, 1, 0, 0);
    chk("strb_model", model[2], 16'hAB34);
    do_read(4'd2, 0);
    do_write(4'd7, 16'h5A5A, 2'b00, 0, 0, 1);
    do_read(4'd7, 0);

    // Commit to reg 5 on the same edge the AR for reg 5 is accepted.
    do_write(4'd5, 16'h0011, 2'b11, 0, 0, 0);
    @(negedge clk);
    bus.aw_addr = 4'd5; bus.aw_valid = 1'b1;
    bus.w_data = 16'h0022; bus.w_strb = 2'b11; bus.w_valid = 1'b1;
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("same_ar_rdy", bus.ar_ready, 1);
    bus.ar_addr = 4'd5; bus.ar_valid = 1'b1;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    chk("same_r_vld", bus.r_valid, 1);
    chk("same_r_old", bus.r_data, 16'h0011);
    chk("same_b_vld", bus.b_valid, 1);
    model_write(4'd5, 16'h0022, 2'b11);
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    do_read(4'd5, 0);
    chk("same_r_new", model[5], 16'h0022);

    for (int n = 0; n < 30; n++) begin
      do_write(4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
    for (int i = 0; i < 16; i++) do_read(4'(i), 0);

    // Reset with a read response pending drops it immediately and clears the array.
    @(negedge clk);
    bus.ar_addr = 4'd5; bus.ar_valid = 1'b1;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    chk("pre_rst_r_vld", bus.r_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_r_vld", bus.r_valid, 0);
    chk("rst_mid_r_data", bus.r_data, 0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_r_vld", bus.r_valid, 0);
    chk("post_rst_b_vld", bus.b_valid, 0);
    chk("post_rst_disp", disp_out, 0);
    do_read(4'd5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
Parametrised AXI4-Lite-style register-file slave. It has independent AW, W, B, AR and R channels and configurable address/data width and depth. It adds a write-response channel, byte strobes, out-of-range error responses and a mirrored display register. It sits behind the top-level pin wrapper and drives the hex display output from one selected register.

Parameters:
ADDR_W, 4, address width in bits (word addresses).
DATA_W, 8, register width in bits; must be a multiple of 8.
DEPTH, 16, number of implemented registers; 1 <= DEPTH <= 2**ADDR_W.
DISP_IDX, 0, index of the register mirrored onto disp_out; must be < DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
aw_addr  input  ADDR_W  write address
aw_valid  input  1  write address valid
aw_ready  output  1  write address ready
w_data  input  DATA_W  write data
w_strb  input  DATA_W/8  byte write enables
w_valid  input  1  write data valid
w_ready  output  1  write data ready
b_resp  output  2  write response (00 OKAY, 10 SLVERR)
b_valid  output  1  write response valid
b_ready  input  1  write response ready
ar_addr  input  ADDR_W  read address
ar_valid  input  1  read address valid
ar_ready  output  1  read address ready
r_data  output  DATA_W  read data
r_resp  output  2  read response
r_valid  output  1  read data valid
r_ready  input  1  read data ready
disp_out  output  DATA_W  live copy of register DISP_IDX

Behaviour:
- Reset (async, rst_n=0): all registers 0. aw_ready=w_ready=ar_ready=1. b_valid=r_valid=0. r_data=0, b_resp=r_resp=00, disp_out=0. Reset mid-transaction abandons it; no response is issued after release.
- Handshake: a transfer occurs on an edge where valid&&ready. Valid may assert before or after ready. Outputs hold stable while valid&&!ready.
- Write FSM states:
  - W_IDLE: both readies high.
  - AW and W are captured independently into holding regs. Each ready drops after its own capture. Capture order is free, same cycle included.
  - W_COMMIT is entered once both are held. On the next edge: array update per w_strb (byte i written iff w_strb[i]); b_valid<=1; b_resp=00 if addr<DEPTH, else 10.
  - W_RESP: hold b_valid/b_resp until b_ready. On the handshake edge, b_valid<=0 and aw_ready=w_ready<=1 (back to W_IDLE).
  - Latency: AW+W together at edge N, commit and b_valid visible after edge N+1. New AW/W is accepted only after the B handshake, so at most 1 outstanding write.
- Out-of-range write (addr>=DEPTH): no register changes; SLVERR response.
- w_strb=0 in range: no change; OKAY response.
- Read FSM states:
  - R_IDLE: ar_ready=1. On the AR handshake at edge N: r_data<=reg[ar_addr] (0 if out of range), r_resp 00/10, r_valid<=1, ar_ready<=0.
  - R_DATA: hold r_data/r_resp/r_valid until r_ready. On the handshake edge, r_valid<=0 and ar_ready<=1. Back-to-back throughput is 1 read per 2 cycles.
- Read and write channels are fully independent and may be active simultaneously.
- AR handshake on the same edge as a commit to the same address: r_data returns the pre-write value. A read accepted on any later edge sees the new value.
- disp_out is combinational from register DISP_IDX. It changes on the commit edge.
- Width rule: ar_addr/aw_addr compared unsigned against DEPTH. When DEPTH==2**ADDR_W, SLVERR is impossible.

Decomposition:
- Package axil_pkg: resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10; write-state enum {W_IDLE, W_COMMIT, W_RESP}; read-state enum {R_IDLE, R_DATA}.
- One sub-module, axil_regfile_mem: DEPTH x DATA_W storage with async-reset clear, byte-strobed write port, one combinational read port for r_data and one fixed tap for disp_out. Channel FSMs stay in the top.

Test Plan:
- Reset, then write addr 3 data 8'hA5 strb 1, AW and W in same cycle; b_ready=1 -> b_valid one cycle after commit edge, b_resp=00. Read addr 3 -> r_data=8'hA5, r_resp=00.
- W presented 3 cycles before AW (addr 0, data 8'h4C) -> w_ready low after capture, no commit until AW. After commit, disp_out=8'h4C (DISP_IDX=0) and b_resp=00.
- DEPTH=12: write addr 13, then read addr 13 -> b_resp=10, r_resp=10, r_data=0, all 12 registers unchanged.
- b_ready held low 5 cycles -> b_valid and b_resp stable, aw_ready=w_ready=0 throughout, second AW ignored until B handshake. Same check on R with r_ready low.
- DATA_W=16: reg 2=16'h1234, write 16'hABCD strb 2'b10 -> read returns 16'hAB34.
- Reg 5=8'h11. Commit of 8'h22 to reg 5 on the same edge as an AR to 5 -> r_data=8'h11. Next read -> 8'h22. Assert rst_n=0 while r_valid pending -> r_valid=0 immediately, reg 5 reads 0.
